// File: rtl/comb_chk_pkg.sv
// Shared definitions for the comb_* response checker.
//   state_t        : checker FSM states (IDLE, RUN, DONE)
//   *_DEF          : default sweep length, golden truth table and MISR polynomial
//   ERR_CNT_MAX    : saturation value of the 5-bit error counter
package comb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          N_VEC_DEF     = 16;
  localparam logic [15:0] EXP_TABLE_DEF = 16'h6996;
  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
  localparam logic [4:0]  ERR_CNT_MAX   = 5'd31;

endpackage

// File: rtl/comb_misr.sv
// 16-bit multiple-input signature register folding a 4-bit response word.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the signature
//   clr  : synchronous clear (start of a new sweep)
//   en   : fold din into the signature this cycle
//   din  : 4-bit response word
//   sig  : current signature
module comb_misr
  import comb_chk_pkg::*;
#(
  parameter logic [15:0] POLY = MISR_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ ({16{sig[15]}} & POLY) ^ {12'b0, din};
    end
  end

endmodule

// File: rtl/comb_resp_check.sv
// Response checker for the four comb_* implementations of one 4-input
// function. Receives the exhaustive stimulus sweep, compares every
// implementation against a golden truth table, checks sweep order and
// folds the responses into a MISR signature.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : begin a sweep (honoured in IDLE and DONE)
//   vec_valid       : vec/y valid this cycle
//   vec             : stimulus {A,B,C,D}
//   y               : responses {Y4,Y3,Y2,Y1}
//   busy, done      : sweep running / sweep finished (level)
//   pass            : done with zero failing vectors
//   err_cnt         : failing vectors, saturating at 31
//   first_err_vld   : a failure was recorded this sweep
//   first_err_vec   : vec of the first failing vector
//   signature       : MISR state
module comb_resp_check
  import comb_chk_pkg::*;
#(
  parameter int          N_VEC     = N_VEC_DEF,
  parameter logic [15:0] EXP_TABLE = EXP_TABLE_DEF,
  parameter logic [15:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        vec_valid,
  input  logic [3:0]  vec,
  input  logic [3:0]  y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic        first_err_vld,
  output logic [3:0]  first_err_vec,
  output logic [15:0] signature
);

  localparam int IDX_W = (N_VEC > 1) ? $clog2(N_VEC) : 1;

  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 5'd1;
  endfunction

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [4:0]         err_nxt;
  logic               fev_nxt;
  logic [3:0]         fvec_nxt;
  logic               clr_sweep;
  logic               accept;
  logic               exp_bit;
  logic               order_err;
  logic               value_err;
  logic               last_vec;

  // Value check uses the received vec even when it arrives out of order;
  // an out-of-order vector with wrong values still counts only once.
  assign exp_bit   = EXP_TABLE[vec];
  assign value_err = |(y ^ {4{exp_bit}});
  assign order_err = (32'(idx) != 32'(vec));
  assign last_vec  = (idx == IDX_W'(N_VEC - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = err_cnt;
    fev_nxt   = first_err_vld;
    fvec_nxt  = first_err_vec;
    clr_sweep = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          clr_sweep = 1'b1;
        end
      end
      RUN: begin
        if (vec_valid) begin
          accept = 1'b1;
          if (order_err || value_err) begin
            err_nxt = sat_inc(err_cnt);
            if (!first_err_vld) begin
              fev_nxt  = 1'b1;
              fvec_nxt = vec;
            end
          end
          // idx stops at the last index so it never wraps within a sweep
          if (last_vec) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr_sweep) begin
      idx_nxt  = '0;
      err_nxt  = '0;
      fev_nxt  = 1'b0;
      fvec_nxt = '0;
    end
  end

  // Status outputs are registered from the next-state decode so they
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      err_cnt       <= err_nxt;
      first_err_vld <= fev_nxt;
      first_err_vec <= fvec_nxt;
      busy          <= (state_nxt == RUN);
      done          <= (state_nxt == DONE);
      pass          <= (state_nxt == DONE) && (err_nxt == 5'd0);
    end
  end

  comb_misr #(
    .POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_sweep),
    .en   (accept),
    .din  (y),
    .sig  (signature)
  );

endmodule
